fft_mag_scheduler: RTL

Frame-granular round-robin scheduler that shares one fixed-latency FFT magnitude datapath (fixed→float, square, add, sqrt, float→fixed) between NUM_CH FFT output streams. It gates each channel's samples into the datapath and carries a {channel, bin, sof, eof} tag through a delay line matched to the datapath latency. Results leave the block tagged and aligned with their valid. It sits between the per-channel FFT cores and the spectrum writer.

---
 rtl/fft_mag_scheduler.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fft_mag_scheduler.sv
// Frame-granular round-robin scheduler sharing one fixed-latency FFT magnitude
// datapath between NUM_CH streams; a tag line tracks each sample to its result.
module fft_mag_scheduler #(
  parameter int NUM_CH    = 2,
  parameter int FRAME_LEN = 1024,
  parameter int PIPE_LAT  = 32,
  parameter int DW        = 20,
  parameter int MW        = 21,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int BW = $clog2(FRAME_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    ch_valid,
  input  logic [NUM_CH-1:0]    ch_sof,
  input  logic [NUM_CH*DW-1:0] ch_real,
  input  logic [NUM_CH*DW-1:0] ch_imag,
  output logic [NUM_CH-1:0]    ch_ready,
  output logic                 dp_valid,
  output logic [DW-1:0]        dp_real,
  output logic [DW-1:0]        dp_imag,
  input  logic [MW-1:0]        dp_mag,
  output logic                 mag_valid,
  output logic [MW-1:0]        mag_out,
  output logic [CW-1:0]        mag_ch,
  output logic [BW-1:0]        mag_bin,
  output logic                 mag_sof,
  output logic                 mag_eof,
  output logic                 busy,
  output logic [NUM_CH-1:0]    err_sticky
);

  typedef enum logic {IDLE, STREAM} state_t;

  typedef struct packed {
    logic          v;
    logic [CW-1:0] ch;
    logic [BW-1:0] bin;
    logic          sof;
    logic          eof;
  } tag_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     grant, grant_nxt, rr_ptr;
  logic [BW-1:0]     bin_cnt;
  logic              hs_stream, last_bin;
  logic [NUM_CH-1:0] sof_req, flush, err_set;
  tag_t              issue_tag, exit_tag;
  tag_t              tag_line [PIPE_LAT+1];

  function automatic logic [CW-1:0] wrap_idx(input logic [CW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CW'(s);
  endfunction

  assign sof_req   = ch_valid & ch_sof;
  assign hs_stream = (state == STREAM) && ch_valid[grant];
  assign last_bin  = (bin_cnt == BW'(FRAME_LEN-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      grant   <= '0;
      rr_ptr  <= '0;
      bin_cnt <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (hs_stream) begin
        if (last_bin) begin
          bin_cnt <= '0;
          rr_ptr  <= (grant == CW'(NUM_CH-1)) ? '0 : grant + 1'b1;
        end else begin
          bin_cnt <= bin_cnt + 1'b1;
        end
      end
    end
  end

  // Descending scan so the smallest offset from rr_ptr wins the grant.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        for (int i = NUM_CH-1; i >= 0; i--) begin
          if (sof_req[wrap_idx(rr_ptr, i)]) begin
            grant_nxt = wrap_idx(rr_ptr, i);
            state_nxt = STREAM;
          end
        end
      end
      STREAM: if (hs_stream && last_bin) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    flush   = '0;
    err_set = '0;
    if (state == IDLE) flush = ch_valid & ~ch_sof;
    if (hs_stream && ch_sof[grant] && (bin_cnt != '0)) err_set[grant] = 1'b1;
  end

  always_comb begin
    ch_ready = '0;
    case (state)
      IDLE:    ch_ready = flush;
      STREAM:  ch_ready[grant] = 1'b1;
      default: ch_ready = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_sticky <= '0;
    else      err_sticky <= err_sticky | flush | err_set;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_tag <= '0;
      dp_real   <= '0;
      dp_imag   <= '0;
    end else begin
      issue_tag <= {hs_stream, grant, bin_cnt, (bin_cnt == '0), last_bin};
      if (hs_stream) begin
        dp_real <= ch_real[grant*DW +: DW];
        dp_imag <= ch_imag[grant*DW +: DW];
      end
    end
  end

  assign dp_valid = issue_tag.v;

  // One stage beyond PIPE_LAT accounts for the datapath's own input register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= PIPE_LAT; i++) tag_line[i] <= '0;
    end else begin
      tag_line[0] <= issue_tag;
      for (int i = 1; i <= PIPE_LAT; i++) tag_line[i] <= tag_line[i-1];
    end
  end

  assign exit_tag = tag_line[PIPE_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mag_valid <= 1'b0;
      mag_out   <= '0;
      mag_ch    <= '0;
      mag_bin   <= '0;
      mag_sof   <= 1'b0;
      mag_eof   <= 1'b0;
    end else begin
      mag_valid <= exit_tag.v;
      mag_sof   <= exit_tag.v & exit_tag.sof;
      mag_eof   <= exit_tag.v & exit_tag.eof;
      if (exit_tag.v) begin
        mag_out <= dp_mag;
        mag_ch  <= exit_tag.ch;
        mag_bin <= exit_tag.bin;
      end
    end
  end

  always_comb begin
    busy = (state == STREAM) | issue_tag.v;
    for (int i = 0; i <= PIPE_LAT; i++) busy = busy | tag_line[i].v;
  end

endmodule
